oam_dma: RTL
============

# oam_dma

Sprite-attribute DMA engine for the NES core. It is the writer side of the dual-port block RAM that holds OAM. On a CPU write to $4014 it halts the CPU and copies one 256-byte page of CPU address space into OAM through one RAM port. It sits between the CPU bus arbiter (source reads, RDY/halt) and the PPU's OAM dual-port RAM (destination writes).

## Interface
- `SRC_ADDR_WIDTH`, default 16: CPU address bus width. The upper bits above 16 are zero.
- `OAM_ADDR_WIDTH`, default 8: OAM RAM address width. The transfer length is `1 << OAM_ADDR_WIDTH` bytes.
- `DATA_WIDTH`, default 8: byte width of the source and OAM data.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  CPU cycle enable. The FSM advances only on clk edges where `ce`=1.
- `start`  in  1  one-clk pulse, qualified by `ce`, produced by the $4014 write.
- `page`  in  8  source page. It is captured when `start` is accepted.
- `oam_base`  in  OAM_ADDR_WIDTH  current OAMADDR. It is captured when `start` is accepted.
- `odd_cycle`  in  1  high when the current CPU cycle is odd.
- `cpu_halt`  out  1  registered. While it is high the CPU is stalled and the bus belongs to this block.
- `busy`  out  1  registered. High from acceptance of `start` until the final write completes.
- `done`  out  1  registered. One-clk pulse after the final write.
- `src_rd`  out  1  source read strobe.
- `src_addr`  out  SRC_ADDR_WIDTH  source address, equal to `{page_r, cnt}`.
- `src_din`  in  DATA_WIDTH  source read data. It is valid the clk after `src_rd`, which is fixed registered-read latency.
- `oam_we`  out  1  OAM port write enable.
- `oam_addr`  out  OAM_ADDR_WIDTH  OAM write address.
- `oam_dout`  out  DATA_WIDTH  OAM write data.

## Operation
- **Reset values.** All registers and outputs are 0 and the state is IDLE. This includes `cpu_halt`, `busy`, `done`, `src_rd`, `src_addr`, `oam_we`, `oam_addr` and `oam_dout`.
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE.** On `ce && start`:
  - capture `page` into `page_r` and `oam_base` into `oam_ptr`;
  - clear the 8-bit `cnt`;
  - set `busy` and `cpu_halt`;
  - go to HALT.
- **HALT** (one ce cycle, the dummy cycle). On ce, if `odd_cycle`=1 go to ALIGN, else go to READ.
- **ALIGN** (one ce cycle). On ce, go to READ.
- **READ.**
  - `src_rd = ce` while in READ.
  - `src_addr = {page_r, cnt}`.
  - On ce, go to WRITE.
- **WRITE.**
  - `oam_we = ce` while in WRITE.
  - `oam_addr = oam_ptr`.
  - On ce: increment `oam_ptr` and `cnt`, both modulo 2^width.
  - If `cnt` was all ones: clear `cpu_halt` and `busy`, pulse `done`, and go to IDLE.
  - Otherwise go to READ.
- **Data path.** `data_hold` captures `src_din` at the end of the clk that follows any `src_rd` clk.
  - `oam_dout = src_din` in the clk directly after the `src_rd` clk.
  - `oam_dout = data_hold` in all other clks.
  - As a result the write data is correct whether or not `ce` gaps separate READ and WRITE.
- **Output decoding.** `src_rd`, `src_addr`, `oam_we`, `oam_addr` and `oam_dout` are combinational from registered state and counters. When idle, `src_rd` and `oam_we` are 0.
- **Destination wrap.** The OAM address wraps: `oam_base`=0xF0 writes 0xF0..0xFF and then 0x00..0xEF. The source never leaves the page, because `cnt` is only 8 bits.
- **Start while busy.** `start` is ignored while `busy`=1. No restart and no parameter recapture.
- **Stalled ce.** With `ce`=0 the state, counters and strobes hold. `src_rd`/`oam_we` are qualified by `ce`, so no strobe occurs.
- **Reset mid-transfer.** `rst` immediately forces IDLE and drops `cpu_halt`. No `done` pulse is produced. A partially written OAM is left as is.

## Timing
- With `ce`=1 every clk, `start` accepted at clk 0:
  - clk 1 is HALT;
  - with `odd_cycle`=1, clk 2 is ALIGN;
  - then 256 READ/WRITE pairs follow.
- **Halt duration.** `cpu_halt` is high for 513 clks when even and 514 clks when odd, matching 2A03 DMA timing.
- **Completion.** `done` is high in the clk after the last WRITE; `busy` and `cpu_halt` are 0 in that same clk.
- **Read-to-write latency.** The read strobe is followed by the write in the next ce cycle: exactly 1 clk when there is no ce gap, and N clks with gaps.
- **Back-to-back transfers.** A new `start` is accepted in the same clk as `done`, because the state is already IDLE.

## Test plan
- **Even transfer.** `ce`=1, `odd_cycle`=0, `page`=0x02, `oam_base`=0, source[0x0200+i]=i^0x5A → OAM[i]=i^0x5A for all 256 bytes; `cpu_halt` high exactly 513 clks; one `done` pulse.
- **Odd alignment.** `odd_cycle`=1 during HALT → `cpu_halt` high 514 clks; the first `src_rd` is at clk 3.
- **OAM wrap.** `oam_base`=0xF0, `page`=0x03 → source 0x0300 lands at OAM 0xF0; 0x030F lands at 0xFF; 0x0310 lands at 0x00; the last write is at 0xEF.
- **ce gaps.** `ce` as a 1-in-3 pattern with 2 idle clks between READ and WRITE → data is identical to the ce=1 run; no strobes occur while `ce`=0; `cpu_halt` lasts 3×513 clks.
- **Start while busy.** A second `start` with `page`=0x07 at byte 100 → ignored; all source addresses stay in page 0x02; exactly one `done`.
- **Reset mid-transfer.** Assert `rst` at byte 50 → `cpu_halt`, `busy`, `src_rd` and `oam_we` drop within the same clk; no `done`. A following `start` completes a full 256-byte transfer.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma - sprite-attribute DMA engine (writer side of the OAM dual-port RAM).
//
// A $4014 write pulses start.  The engine then halts the CPU and copies one
// 256-byte page of CPU address space into OAM, starting at the captured
// OAMADDR and wrapping modulo the OAM size.  Each byte is one READ ce-cycle
// followed by one WRITE ce-cycle.  An optional ALIGN cycle is inserted when
// the dummy cycle lands on an odd CPU cycle (2A03 timing: 513 or 514 cycles).
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   ce           CPU cycle enable; the FSM only advances when ce=1
//   start        $4014 write strobe (qualified by ce)
//   page         source page, captured on start
//   oam_base     current OAMADDR, captured on start
//   odd_cycle    current CPU cycle is odd
//   cpu_halt     CPU stall request (registered)
//   busy         transfer in progress (registered)
//   done         one-clk pulse after the final write (registered)
//   src_rd       source read strobe
//   src_addr     source address {page, cnt}
//   src_din      source read data, valid the clk after src_rd
//   oam_we       OAM write enable
//   oam_addr     OAM write address
//   oam_dout     OAM write data
module oam_dma #(
   parameter int unsigned SRC_ADDR_WIDTH = 16,
   parameter int unsigned OAM_ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ce,
   input  logic                      start,
   input  logic [7:0]                page,
   input  logic [OAM_ADDR_WIDTH-1:0] oam_base,
   input  logic                      odd_cycle,
   output logic                      cpu_halt,
   output logic                      busy,
   output logic                      done,
   output logic                      src_rd,
   output logic [SRC_ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0]     src_din,
   output logic                      oam_we,
   output logic [OAM_ADDR_WIDTH-1:0] oam_addr,
   output logic [DATA_WIDTH-1:0]     oam_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t                    state_q, state_d;
   logic [7:0]                page_q, page_d;
   logic [OAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      busy_q, busy_d;
   logic                      halt_q, halt_d;
   logic                      done_q, done_d;
   // src_rd was asserted in the previous clk, so src_din is valid now
   logic                      rd_d1_q;
   logic [DATA_WIDTH-1:0]     hold_q;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         page_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         halt_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_d1_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         halt_q  <= halt_d;
         done_q  <= done_d;
         rd_d1_q <= src_rd;
         // Latch the read data in its single valid clk so that a write
         // delayed by ce gaps still sees the right byte.
         if (rd_d1_q) begin
            hold_q <= src_din;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      halt_d  = halt_q;
      done_d  = 1'b0;
      if (ce) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  page_d  = page;
                  ptr_d   = oam_base;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  halt_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
            S_HALT:  state_d = odd_cycle ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
               ptr_d = ptr_q + OAM_ADDR_WIDTH'(1);
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == '1) begin
                  busy_d  = 1'b0;
                  halt_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------
   always_comb begin
      src_rd   = ce && (state_q == S_READ);
      oam_we   = ce && (state_q == S_WRITE);
      src_addr = SRC_ADDR_WIDTH'({page_q, cnt_q});
      oam_addr = ptr_q;
      oam_dout = rd_d1_q ? src_din : hold_q;
      cpu_halt = halt_q;
      busy     = busy_q;
      done     = done_q;
   end

endmodule
